// File: rtl/mod_det_4x4_ctrl.sv
// Sequencer between a byte stream of 16 signed matrix elements and the 4x4 determinant unit.
// Optional WAIT-state watchdog enabled by defining DET_TIMEOUT_EN.
module mod_det_4x4_ctrl #(
    parameter int ELEM_W         = 8,
    parameter int RES_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W-1:0]     in_data,
    output logic [16*ELEM_W-1:0]  det_mat,
    output logic                  det_start,
    input  logic [RES_W-1:0]      det_resultado,
    input  logic                  det_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RES_W-1:0]      out_data,
    output logic                  out_err,
    output logic                  busy
);

    typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [16*ELEM_W-1:0] mat_q, mat_d;
    logic                 start_q, start_d;
    logic                 valid_q, valid_d;
    logic [RES_W-1:0]     data_q, data_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

`ifdef DET_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

    assign in_ready  = (state_q == LOAD);
    assign det_mat   = mat_q;
    assign det_start = start_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign busy      = busy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mat_d   = mat_q;
        start_d = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef DET_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    for (int unsigned k = 0; k < 16; k++) begin
                        if (idx_q == 4'(k)) mat_d[k*ELEM_W +: ELEM_W] = in_data;
                    end
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = START;
                        start_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
`ifdef DET_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // det_done takes priority over a watchdog expiry in the same cycle
                if (det_done) begin
                    data_d  = det_resultado;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = OUT;
                end
`ifdef DET_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            mat_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DET_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mat_q   <= mat_d;
            start_q <= start_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef DET_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_mod_det_4x4_ctrl.sv
// Bench for mod_det_4x4_ctrl with a behavioural determinant unit and a result scoreboard.
module tb_mod_det_4x4_ctrl;

    localparam int LAT = 4;
    localparam int TO  = 64;

    typedef int ia16_t [16];
    typedef struct {
        logic [127:0] m;
        logic [15:0]  exp;
    } vec_t;
    typedef struct packed {
        logic [15:0] d;
        logic        e;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic [127:0] det_mat;
    logic         det_start;
    logic [15:0]  det_resultado = '0;
    logic         det_done = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [15:0]  out_data;
    logic         out_err;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    res_t sb[$];

    logic         stub_en = 1'b1;
    logic         exp_ov_on_done = 1'b1;
    logic [127:0] exp_mat = '0;
    int           start_cnt = 0;
    int           scnt = 0;

    mod_det_4x4_ctrl #(.ELEM_W(8), .RES_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .det_mat(det_mat), .det_start(det_start),
        .det_resultado(det_resultado), .det_done(det_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input ia16_t e);
        logic [127:0] m;
        for (int k = 0; k < 16; k++) m[k*8 +: 8] = 8'(e[k]);
        return m;
    endfunction

    function automatic int el(input logic [127:0] m, input int r, input int c);
        logic signed [7:0] b;
        b = m[(r*4+c)*8 +: 8];
        return int'(b);
    endfunction

    function automatic int det3(input logic [127:0] m, input int c0, input int c1, input int c2);
        return el(m,1,c0) * (el(m,2,c1)*el(m,3,c2) - el(m,2,c2)*el(m,3,c1))
             - el(m,1,c1) * (el(m,2,c0)*el(m,3,c2) - el(m,2,c2)*el(m,3,c0))
             + el(m,1,c2) * (el(m,2,c0)*el(m,3,c1) - el(m,2,c1)*el(m,3,c0));
    endfunction

    function automatic int det4(input logic [127:0] m);
        return el(m,0,0)*det3(m,1,2,3) - el(m,0,1)*det3(m,0,2,3)
             + el(m,0,2)*det3(m,0,1,3) - el(m,0,3)*det3(m,0,1,2);
    endfunction

    // Behavioural determinant unit: result LAT cycles after det_start
    always @(negedge clk) begin
        if (det_done) begin
            if (exp_ov_on_done) chk("done_to_out_valid", 128'(out_valid), 128'(1));
            else                chk("late_done_ignored", 128'(out_valid), 128'(0));
        end
        det_done = 1'b0;
        if (det_start) begin
            start_cnt++;
            chk("det_mat_at_start", det_mat, exp_mat);
            scnt = LAT;
        end else if (scnt > 0) begin
            scnt--;
            if (scnt == 0 && stub_en) begin
                det_done      = 1'b1;
                det_resultado = 16'(det4(det_mat));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 128'(out_data), 128'(16'hDEAD));
            end else begin
                res_t r;
                r = sb.pop_front();
                chk("out_data", 128'(out_data), 128'(r.d));
                chk("out_err", 128'(out_err), 128'(r.e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] m, input logic push, input res_t r,
                        input int nbeats, input logic gaps);
        logic ir;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    cyc();
                end
            end
            in_valid = 1'b1;
            in_data  = m[k*8 +: 8];
            if (k == 15) begin
                exp_mat = m;
                if (push) sb.push_back(r);
            end
            ir = in_ready;
            cyc();
            chk("in_ready_load", 128'(ir), 128'(1));
        end
        in_valid = 1'b0;
        if (nbeats == 16) begin
            @(negedge clk);
            chk("start_latency", 128'(det_start), 128'(1));
            chk("busy_in_start", 128'(busy), 128'(1));
            cyc();
        end
    endtask

    task automatic wait_out();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("out_valid_arrives", 128'(seen), 128'(1));
    endtask

    task automatic after_hs(input int s0);
        cyc();
        @(negedge clk);
        chk("busy_after_hs", 128'(busy), 128'(0));
        chk("in_ready_after_hs", 128'(in_ready), 128'(1));
        chk("out_valid_after_hs", 128'(out_valid), 128'(0));
        chk("single_start_pulse", 128'(start_cnt - s0), 128'(1));
        cyc();
    endtask

    task automatic run(input vec_t v, input logic gaps);
        int s0;
        s0 = start_cnt;
        send(v.m, 1'b1, '{d: v.exp, e: 1'b0}, 16, gaps);
        wait_out();
        after_hs(s0);
    endtask

    task automatic chk_reset(input string nm);
        @(negedge clk);
        chk({nm, "_det_mat"}, det_mat, '0);
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
        chk({nm, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({nm, "_out_data"}, 128'(out_data), 128'(0));
        chk({nm, "_out_err"}, 128'(out_err), 128'(0));
        chk({nm, "_det_start"}, 128'(det_start), 128'(0));
        cyc();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t vecs [7];
        logic [127:0] ident;
        logic [15:0]  d0;
        int           n, s0;

        ident = pk('{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1});
        vecs[0] = '{m: ident, exp: 16'h0001};
        vecs[1] = '{m: pk('{2,0,0,0, 0,3,0,0, 0,0,4,0, 0,0,0,5}), exp: 16'h0078};
        vecs[2] = '{m: pk('{-1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1}), exp: 16'hFFFF};
        vecs[3] = '{m: pk('{1,2,3,4, 1,2,3,4, 0,1,0,0, 0,0,1,0}), exp: 16'h0000};
        vecs[4] = '{m: pk('{2,1,0,3, 0,-3,5,1, 0,0,4,7, 0,0,0,-2}), exp: 16'h0030};
        vecs[5] = '{m: pk('{0,1,0,0, 1,0,0,0, 0,0,1,0, 0,0,0,1}), exp: 16'hFFFF};
        vecs[6] = '{m: pk('{100,0,0,0, 0,100,0,0, 0,0,100,0, 0,0,0,100}), exp: 16'hE100};

        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        chk_reset("reset");

        for (int i = 0; i < 7; i++) run(vecs[i], i[0]);

        // Consumer stalls 10 cycles while the stream keeps offering beats
        out_ready = 1'b0;
        send(vecs[1].m, 1'b1, '{d: 16'h0078, e: 1'b0}, 16, 1'b1);
        s0 = start_cnt - 1;
        wait_out();
        d0 = out_data;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_out_data", 128'(out_data), 128'(d0));
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            if (i < 9) @(negedge clk);
        end
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        after_hs(s0);
        run(vecs[2], 1'b1);

        // Reset after a partial matrix must discard it
        send(vecs[6].m, 1'b0, '{d: 16'h0, e: 1'b0}, 7, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_reset("rst_partial");
        run(vecs[0], 1'b0);

        // Reset in WAIT: the determinant unit's late det_done must be ignored
        exp_ov_on_done = 1'b0;
        send(vecs[1].m, 1'b0, '{d: 16'h0, e: 1'b0}, 16, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("rst_wait_no_out_valid", 128'(n), 128'(0));
        exp_ov_on_done = 1'b1;
        cyc();
        run(vecs[4], 1'b1);

`ifdef DET_TIMEOUT_EN
        stub_en = 1'b0;
        s0 = start_cnt;
        send(ident, 1'b1, '{d: 16'h0, e: 1'b1}, 16, 1'b0);
        n = 0;
        for (int i = 0; i < 500 && !out_valid; i++) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 128'(n), 128'(TO + 1));
        after_hs(s0);
        stub_en = 1'b1;
`else
        stub_en = 1'b0;
        send(ident, 1'b0, '{d: 16'h0, e: 1'b0}, 16, 1'b0);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        chk("no_timeout_out_valid", 128'(n), 128'(0));
        stub_en = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
`endif
        run(vecs[3], 1'b1);

        chk("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
